// File: rtl/tlp_frag_sequencer_pkg.sv
// Shared TL TX definitions: Fmt encodings, header bit offsets and sequencer FSM states.
`default_nettype none

package tlp_frag_sequencer_pkg;

  localparam logic [2:0] FMT_3DW_NODATA = 3'b000;
  localparam logic [2:0] FMT_4DW_NODATA = 3'b001;
  localparam logic [2:0] FMT_3DW_DATA   = 3'b010;
  localparam logic [2:0] FMT_4DW_DATA   = 3'b011;

  localparam int FMT_4DW_BIT  = 0;
  localparam int FMT_DATA_BIT = 1;

  localparam int HDR_FMT_MSB = 127;
  localparam int HDR_FMT_LSB = 125;
  localparam int HDR_TD_BIT  = 111;
  localparam int HDR_LEN_MSB = 105;
  localparam int HDR_LEN_LSB = 96;

  localparam int TOT_W = 11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BODY     = 2'd1,
    ST_ECRC_PAD = 2'd2
  } frag_state_e;

endpackage

`default_nettype wire

// File: rtl/tlp_frag_sequencer_len_calc.sv
// Combinational header decode: buffer beat count, pad flag, last-beat DW count and ECRC slot.
`default_nettype none

module frag_len_calc
  import tlp_frag_sequencer_pkg::*;
#(
  parameter int CNT_W = 9
) (
  input  logic [1:0]       fmt,
  input  logic             td,
  input  logic [9:0]       len,
  output logic [CNT_W-1:0] buf_beats,
  output logic             pad,
  output logic [2:0]       last_dw_valid,
  output logic [1:0]       ecrc_pos
);

  logic [TOT_W-1:0] h;
  logic [TOT_W-1:0] d;
  logic [TOT_W-1:0] hd;
  logic [TOT_W-1:0] tot;
  logic [TOT_W-1:0] hd_rnd;

  always_comb begin
    h = fmt[FMT_4DW_BIT] ? 11'd4 : 11'd3;
    d = '0;
    // A Length of zero encodes the maximum 1024-DW payload.
    if (fmt[FMT_DATA_BIT]) begin
      d = (len == 10'd0) ? 11'd1024 : {1'b0, len};
    end
    hd            = h + d;
    tot           = hd + {10'd0, td};
    hd_rnd        = hd + 11'd3;
    buf_beats     = CNT_W'(hd_rnd >> 2);
    pad           = td & (hd[1:0] == 2'b00);
    last_dw_valid = (tot[1:0] == 2'b00) ? 3'd4 : {1'b0, tot[1:0]};
    ecrc_pos      = tot[1:0] - 2'd1;
  end

endmodule

`default_nettype wire

// File: rtl/tlp_frag_sequencer.sv
// Pulls TLP beats from a FWFT TX buffer and presents them, with sop/eop, DW-valid and
// ECRC-slot sideband, on a registered valid/ready beat interface.
`default_nettype none

module tlp_frag_sequencer
  import tlp_frag_sequencer_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int CNT_W  = 9
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              buf_empty,
  input  logic [DATA_W-1:0] buf_rd_data,
  output logic              buf_rd_en,
  output logic              frag_valid,
  output logic [DATA_W-1:0] frag_data,
  output logic              frag_sop,
  output logic              frag_eop,
  output logic [2:0]        frag_dw_valid,
  output logic              ecrc_init,
  output logic              ecrc_insert,
  output logic [1:0]        ecrc_pos,
  input  logic              dll_ready,
  output logic              busy
);

  frag_state_e       state_q, state_d;
  logic [CNT_W-1:0]  reads_left_q, reads_left_d;
  logic              td_q, td_d;
  logic              pad_q, pad_d;
  logic [2:0]        last_dw_q, last_dw_d;
  logic [1:0]        last_pos_q, last_pos_d;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              sop_q, sop_d;
  logic              eop_q, eop_d;
  logic [2:0]        dwv_q, dwv_d;
  logic              init_q, init_d;
  logic              ins_q, ins_d;
  logic [1:0]        pos_q, pos_d;

  logic              out_free;
  logic              pop;
  logic              hdr_td;
  logic [CNT_W-1:0]  calc_beats;
  logic              calc_pad;
  logic [2:0]        calc_last_dw;
  logic [1:0]        calc_pos;

  assign hdr_td = buf_rd_data[HDR_TD_BIT];

  frag_len_calc #(
    .CNT_W (CNT_W)
  ) u_len_calc (
    .fmt           (buf_rd_data[HDR_FMT_LSB+1:HDR_FMT_LSB]),
    .td            (hdr_td),
    .len           (buf_rd_data[HDR_LEN_MSB:HDR_LEN_LSB]),
    .buf_beats     (calc_beats),
    .pad           (calc_pad),
    .last_dw_valid (calc_last_dw),
    .ecrc_pos      (calc_pos)
  );

  assign out_free  = !valid_q || dll_ready;
  assign pop       = out_free && !buf_empty &&
                     ((state_q == ST_IDLE) ||
                      ((state_q == ST_BODY) && (reads_left_q != '0)));
  assign buf_rd_en = pop;

  always_comb begin
    state_d      = state_q;
    reads_left_d = reads_left_q;
    td_d         = td_q;
    pad_d        = pad_q;
    last_dw_d    = last_dw_q;
    last_pos_d   = last_pos_q;
    valid_d      = valid_q;
    data_d       = data_q;
    sop_d        = sop_q;
    eop_d        = eop_q;
    dwv_d        = dwv_q;
    init_d       = init_q;
    ins_d        = ins_q;
    pos_d        = pos_q;

    if (out_free) begin
      valid_d = 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (pop) begin
            valid_d      = 1'b1;
            data_d       = buf_rd_data;
            sop_d        = 1'b1;
            init_d       = hdr_td;
            td_d         = hdr_td;
            pad_d        = calc_pad;
            last_dw_d    = calc_last_dw;
            last_pos_d   = calc_pos;
            reads_left_d = calc_beats - CNT_W'(1);
            eop_d        = 1'b0;
            dwv_d        = 3'd4;
            ins_d        = 1'b0;
            pos_d        = 2'd0;
            if (calc_beats != CNT_W'(1)) begin
              state_d = ST_BODY;
            end else if (calc_pad) begin
              state_d = ST_ECRC_PAD;
            end else begin
              eop_d = 1'b1;
              dwv_d = calc_last_dw;
              ins_d = hdr_td;
              pos_d = hdr_td ? calc_pos : 2'd0;
            end
          end
        end
        ST_BODY: begin
          if (pop) begin
            valid_d      = 1'b1;
            data_d       = buf_rd_data;
            sop_d        = 1'b0;
            init_d       = 1'b0;
            reads_left_d = reads_left_q - CNT_W'(1);
            eop_d        = 1'b0;
            dwv_d        = 3'd4;
            ins_d        = 1'b0;
            pos_d        = 2'd0;
            if (reads_left_q == CNT_W'(1)) begin
              if (pad_q) begin
                state_d = ST_ECRC_PAD;
              end else begin
                state_d = ST_IDLE;
                eop_d   = 1'b1;
                dwv_d   = last_dw_q;
                ins_d   = td_q;
                pos_d   = td_q ? last_pos_q : 2'd0;
              end
            end
          end
        end
        ST_ECRC_PAD: begin
          // Payload ended on a beat boundary, so the ECRC needs a beat of its own.
          valid_d = 1'b1;
          data_d  = '0;
          sop_d   = 1'b0;
          init_d  = 1'b0;
          eop_d   = 1'b1;
          dwv_d   = 3'd1;
          ins_d   = 1'b1;
          pos_d   = 2'd0;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q      <= ST_IDLE;
      reads_left_q <= '0;
      td_q         <= 1'b0;
      pad_q        <= 1'b0;
      last_dw_q    <= 3'd0;
      last_pos_q   <= 2'd0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      sop_q        <= 1'b0;
      eop_q        <= 1'b0;
      dwv_q        <= 3'd0;
      init_q       <= 1'b0;
      ins_q        <= 1'b0;
      pos_q        <= 2'd0;
    end else begin
      state_q      <= state_d;
      reads_left_q <= reads_left_d;
      td_q         <= td_d;
      pad_q        <= pad_d;
      last_dw_q    <= last_dw_d;
      last_pos_q   <= last_pos_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      sop_q        <= sop_d;
      eop_q        <= eop_d;
      dwv_q        <= dwv_d;
      init_q       <= init_d;
      ins_q        <= ins_d;
      pos_q        <= pos_d;
    end
  end

  assign frag_valid    = valid_q;
  assign frag_data     = data_q;
  assign frag_sop      = sop_q;
  assign frag_eop      = eop_q;
  assign frag_dw_valid = dwv_q;
  assign ecrc_init     = init_q;
  assign ecrc_insert   = ins_q;
  assign ecrc_pos      = pos_q;
  assign busy          = (state_q != ST_IDLE) || valid_q;

endmodule

`default_nettype wire
